aste_spawner: RTL and testbench
===============================

// Module: aste_spawner
// PURPOSE
// - Asteroid slot manager sitting directly downstream of the asteroid spawn ROM (10-bit entries {x[3:0], y[3:0], dir[1:0]}).
// - On each spawn request it drives the ROM address, waits one cycle for the registered-address ROM, and loads the entry into a free slot.
// - On each move tick it steps every active asteroid one cell across the 15x15 grid and retires asteroids that leave it.
// - Slot state feeds the render and collision logic.
// PARAMETERS
// - N_SLOTS    4   number of asteroid slots (power of 2, >=2); SW = log2(N_SLOTS)
// - N_ENTRIES  4   number of ROM entries cycled; address wraps N_ENTRIES-1 -> 0
// - GRID_MAX   14  largest legal coordinate on both axes
// PORTS
// - clk          in   1       system clock, all logic on posedge
// - reset_n      in   1       synchronous reset, active-low
// - spawn_i      in   1       one-cycle spawn request
// - move_i       in   1       one-cycle movement tick
// - kill_i       in   1       remove slot kill_slot_i this cycle (collision)
// - kill_slot_i  in   SW      slot index to kill
// - rom_addr_o   out  4       ROM address (= entry index register)
// - rom_q_i      in   10      ROM data: [9:6]=x, [5:2]=y, [1:0]=dir
// - sel_i        in   SW      slot select for the read port
// - sel_x_o      out  4       x of selected slot (combinational from sel_i)
// - sel_y_o      out  4       y of selected slot
// - sel_dir_o    out  2       direction of selected slot
// - active_o     out  N_SLOTS per-slot active mask
// - busy_o       out  1       high while in FETCH or LOAD
// - drop_o       out  1       one-cycle pulse: spawn request lost
// BEHAVIOUR
// - Reset: state=IDLE; idx=0; every slot inactive with x=y=0, dir=00; active_o=0; busy_o=0; drop_o=0. Reset beats every other input, including mid-FETCH/LOAD.
// - rom_addr_o = idx (registered), constant outside LOAD.
// - FSM: IDLE --spawn_i--> FETCH --> LOAD --> IDLE. FETCH is a single wait cycle covering the ROM address register.
// - In LOAD, rom_q_i is written into the lowest-index inactive slot (per the mask at the start of that cycle), and the slot goes active. Then idx <= (idx==N_ENTRIES-1) ? 0 : idx+1.
// - spawn_i -> loaded slot visible on active_o: 3 cycles.
// - spawn_i while busy: ignored, drop_o=1 next cycle.
// - No free slot in LOAD: nothing written, drop_o=1 next cycle, idx still advances.
// - move_i, per active slot, by dir:
//   - 00: x+1; 01: x-1; 10: y+1; 11: y-1.
//   - If the coordinate is already at the edge in that direction (x==GRID_MAX with 00, x==0 with 01, y==GRID_MAX with 10, y==0 with 11), the slot goes inactive and x/y are held.
//   - Inactive slots never move.
// - Simultaneous events:
//   - kill_i and move_i on the same slot: kill wins.
//   - kill_i on an inactive slot: no effect.
//   - LOAD and move_i in the same cycle: the loaded slot takes raw ROM coordinates (not stepped); the other slots move.
//   - LOAD and kill_i: the kill applies first, but the free-slot search uses the pre-kill mask.
// - dir comes from ROM bits only; no arithmetic wider than 4 bits; coordinates never reach 15.
// CONFIGURATION
// - ASTE_WRAP_EN defined: edge moves wrap instead of retiring the slot (GRID_MAX+dir00 -> x=0, 0+dir01 -> x=GRID_MAX, same on y); slots leave only via kill_i.
// - ASTE_WRAP_EN undefined: edge moves retire the slot as described above.
// TESTING
// - Reset, then spawn_i with ROM entry 0 = {0,7,00} -> after 3 cycles active_o=0001, slot0 (0,7,00), rom_addr_o=1.
// - Four spawns spaced >=3 cycles, then a fifth -> slots 0..3 = (0,7)(14,7)(7,0)(7,14); fifth gives drop_o pulse, active_o=1111, rom_addr_o wraps 0->1.
// - Slot0 (0,7,00) plus 14 move_i -> x=14; 15th move -> active_o[0]=0 (with ASTE_WRAP_EN: x=0, still active).
// - spawn_i on two consecutive cycles -> one load, drop_o high one cycle after the second request.
// - kill_i slot1 with move_i in the same cycle -> slot1 inactive, x unchanged; other slots stepped.
// - Assert reset_n=0 during FETCH -> next cycle IDLE, busy_o=0, active_o=0, rom_addr_o=0.

Source files
------------

// File: rtl/aste_spawner.sv
// ============================================================================
// Module   : aste_spawner
// Brief    : Asteroid slot manager fed by the spawn ROM; loads, moves and
//            retires asteroids on a 15x15 grid. Optional ASTE_WRAP_EN macro
//            makes edge moves wrap instead of retiring the slot.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module aste_spawner #(
    parameter  int N_SLOTS   = 4,
    parameter  int N_ENTRIES = 4,
    parameter  int GRID_MAX  = 14,
    localparam int SW        = $clog2(N_SLOTS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               spawn_i,
    input  logic               move_i,
    input  logic               kill_i,
    input  logic [SW-1:0]      kill_slot_i,
    output logic [3:0]         rom_addr_o,
    input  logic [9:0]         rom_q_i,
    input  logic [SW-1:0]      sel_i,
    output logic [3:0]         sel_x_o,
    output logic [3:0]         sel_y_o,
    output logic [1:0]         sel_dir_o,
    output logic [N_SLOTS-1:0] active_o,
    output logic               busy_o,
    output logic               drop_o
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_LOAD  = 2'd2;

    localparam logic [3:0] c_GRID_MAX = 4'(GRID_MAX);
    localparam logic [3:0] c_IDX_LAST = 4'(N_ENTRIES - 1);

    logic [1:0]         r_state;
    logic [3:0]         r_idx;
    logic               r_drop;
    logic [N_SLOTS-1:0] r_active;
    logic [3:0]         r_x   [N_SLOTS];
    logic [3:0]         r_y   [N_SLOTS];
    logic [1:0]         r_dir [N_SLOTS];

    logic [3:0]         w_nx   [N_SLOTS];
    logic [3:0]         w_ny   [N_SLOTS];
    logic [N_SLOTS-1:0] w_keep;
    logic               w_found;
    logic [SW-1:0]      w_free;
    logic               w_load;

    assign w_load = (r_state == c_ST_LOAD);

    // Lowest-index free slot from the mask before any same-cycle kill.
    always_comb begin
        w_found = 1'b0;
        w_free  = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (!r_active[i] && !w_found) begin
                w_found = 1'b1;
                w_free  = SW'(i);
            end
        end
    end

    // One-cell step per slot; w_keep drops when a move falls off the grid.
    always_comb begin
        for (int i = 0; i < N_SLOTS; i++) begin
            w_nx[i]   = r_x[i];
            w_ny[i]   = r_y[i];
            w_keep[i] = 1'b1;
            case (r_dir[i])
                2'b00: begin
                    if (r_x[i] == c_GRID_MAX) begin
`ifdef ASTE_WRAP_EN
                        w_nx[i] = 4'd0;
`else
                        w_keep[i] = 1'b0;
`endif
                    end else begin
                        w_nx[i] = r_x[i] + 4'd1;
                    end
                end
                2'b01: begin
                    if (r_x[i] == 4'd0) begin
`ifdef ASTE_WRAP_EN
                        w_nx[i] = c_GRID_MAX;
`else
                        w_keep[i] = 1'b0;
`endif
                    end else begin
                        w_nx[i] = r_x[i] - 4'd1;
                    end
                end
                2'b10: begin
                    if (r_y[i] == c_GRID_MAX) begin
`ifdef ASTE_WRAP_EN
                        w_ny[i] = 4'd0;
`else
                        w_keep[i] = 1'b0;
`endif
                    end else begin
                        w_ny[i] = r_y[i] + 4'd1;
                    end
                end
                default: begin
                    if (r_y[i] == 4'd0) begin
`ifdef ASTE_WRAP_EN
                        w_ny[i] = c_GRID_MAX;
`else
                        w_keep[i] = 1'b0;
`endif
                    end else begin
                        w_ny[i] = r_y[i] - 4'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state  <= c_ST_IDLE;
            r_idx    <= 4'd0;
            r_drop   <= 1'b0;
            r_active <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                r_x[i]   <= 4'd0;
                r_y[i]   <= 4'd0;
                r_dir[i] <= 2'b00;
            end
        end else begin
            r_drop <= (spawn_i && (r_state != c_ST_IDLE)) || (w_load && !w_found);

            case (r_state)
                c_ST_IDLE:  if (spawn_i) r_state <= c_ST_FETCH;
                c_ST_FETCH: r_state <= c_ST_LOAD;
                c_ST_LOAD: begin
                    r_state <= c_ST_IDLE;
                    r_idx   <= (r_idx == c_IDX_LAST) ? 4'd0 : r_idx + 4'd1;
                end
                default:    r_state <= c_ST_IDLE;
            endcase

            // Load beats kill (the loaded slot was free, so a kill on it is a no-op),
            // and kill beats move.
            for (int i = 0; i < N_SLOTS; i++) begin
                if (w_load && w_found && (w_free == SW'(i))) begin
                    r_x[i]      <= rom_q_i[9:6];
                    r_y[i]      <= rom_q_i[5:2];
                    r_dir[i]    <= rom_q_i[1:0];
                    r_active[i] <= 1'b1;
                end else if (kill_i && (kill_slot_i == SW'(i))) begin
                    r_active[i] <= 1'b0;
                end else if (move_i && r_active[i]) begin
                    r_x[i]      <= w_nx[i];
                    r_y[i]      <= w_ny[i];
                    r_active[i] <= w_keep[i];
                end
            end
        end
    end

    assign rom_addr_o = r_idx;
    assign sel_x_o    = r_x[sel_i];
    assign sel_y_o    = r_y[sel_i];
    assign sel_dir_o  = r_dir[sel_i];
    assign active_o   = r_active;
    assign busy_o     = (r_state != c_ST_IDLE);
    assign drop_o     = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_aste_spawner.sv
// ============================================================================
// Module   : tb_aste_spawner
// Brief    : Directed self-checking bench for aste_spawner with a registered
//            four-entry spawn ROM model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aste_spawner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       spawn_i;
    logic       move_i;
    logic       kill_i;
    logic [1:0] kill_slot_i;
    logic [3:0] rom_addr_o;
    logic [9:0] rom_q_i;
    logic [1:0] sel_i;
    logic [3:0] sel_x_o;
    logic [3:0] sel_y_o;
    logic [1:0] sel_dir_o;
    logic [3:0] active_o;
    logic       busy_o;
    logic       drop_o;

    int n_total = 0;
    int n_pass  = 0;

    logic [9:0] rom [4];

    aste_spawner dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .spawn_i     (spawn_i),
        .move_i      (move_i),
        .kill_i      (kill_i),
        .kill_slot_i (kill_slot_i),
        .rom_addr_o  (rom_addr_o),
        .rom_q_i     (rom_q_i),
        .sel_i       (sel_i),
        .sel_x_o     (sel_x_o),
        .sel_y_o     (sel_y_o),
        .sel_dir_o   (sel_dir_o),
        .active_o    (active_o),
        .busy_o      (busy_o),
        .drop_o      (drop_o)
    );

    always #5 clk = ~clk;

    // Registered-address ROM: data appears one cycle after the address.
    always @(posedge clk) rom_q_i <= rom[rom_addr_o[1:0]];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic check_slot(input string tag, input int s, input int x, input int y, input int d);
        sel_i = 2'(s);
        #1;
        check({tag, ".x"},   32'(sel_x_o),   32'(x));
        check({tag, ".y"},   32'(sel_y_o),   32'(y));
        check({tag, ".dir"}, 32'(sel_dir_o), 32'(d));
    endtask

    task automatic spawn_and_wait();
        spawn_i = 1'b1;
        step();
        spawn_i = 1'b0;
        step();
        step();
    endtask

    initial begin
        rom[0] = {4'd0,  4'd7,  2'b00};
        rom[1] = {4'd14, 4'd7,  2'b01};
        rom[2] = {4'd7,  4'd0,  2'b10};
        rom[3] = {4'd7,  4'd14, 2'b11};
        rom_q_i     = 10'd0;
        reset_n     = 1'b0;
        spawn_i     = 1'b0;
        move_i      = 1'b0;
        kill_i      = 1'b0;
        kill_slot_i = 2'd0;
        sel_i       = 2'd0;
        step();
        step();

        check("rst.active", 32'(active_o), 32'h0);
        check("rst.busy", 32'(busy_o), 32'h0);
        check("rst.drop", 32'(drop_o), 32'h0);
        check("rst.addr", 32'(rom_addr_o), 32'h0);
        check_slot("rst.s0", 0, 0, 0, 0);

        // First spawn: three-cycle latency to active_o.
        reset_n = 1'b1;
        spawn_i = 1'b1;
        step();
        spawn_i = 1'b0;
        check("sp1.busy_fetch", 32'(busy_o), 32'h1);
        step();
        check("sp1.busy_load", 32'(busy_o), 32'h1);
        check("sp1.active_load", 32'(active_o), 32'h0);
        step();
        check("sp1.active", 32'(active_o), 32'h1);
        check("sp1.busy_idle", 32'(busy_o), 32'h0);
        check("sp1.addr", 32'(rom_addr_o), 32'h1);
        check_slot("sp1.s0", 0, 0, 7, 0);

        spawn_and_wait();
        spawn_and_wait();
        spawn_and_wait();
        check("sp4.active", 32'(active_o), 32'hF);
        check("sp4.addr_wrap", 32'(rom_addr_o), 32'h0);
        check_slot("sp4.s1", 1, 14, 7, 1);
        check_slot("sp4.s2", 2, 7, 0, 2);
        check_slot("sp4.s3", 3, 7, 14, 3);

        // Fifth spawn with all slots full: drop pulse, index still advances.
        spawn_i = 1'b1;
        step();
        spawn_i = 1'b0;
        step();
        step();
        check("sp5.drop", 32'(drop_o), 32'h1);
        check("sp5.active", 32'(active_o), 32'hF);
        check("sp5.addr", 32'(rom_addr_o), 32'h1);
        step();
        check("sp5.drop_end", 32'(drop_o), 32'h0);

        // Kill slot1 together with a move tick.
        kill_i      = 1'b1;
        kill_slot_i = 2'd1;
        move_i      = 1'b1;
        step();
        kill_i = 1'b0;
        move_i = 1'b0;
        check("kill.active", 32'(active_o), 32'hD);
        check_slot("kill.s1", 1, 14, 7, 1);
        check_slot("kill.s0", 0, 1, 7, 0);
        check_slot("kill.s2", 2, 7, 1, 2);
        check_slot("kill.s3", 3, 7, 13, 3);

        // Thirteen more moves bring slot0 to the right edge.
        move_i = 1'b1;
        for (int k = 0; k < 13; k++) step();
        move_i = 1'b0;
        check("edge.active", 32'(active_o), 32'hD);
        check_slot("edge.s0", 0, 14, 7, 0);
        check_slot("edge.s2", 2, 7, 14, 2);
        check_slot("edge.s3", 3, 7, 0, 3);

        move_i = 1'b1;
        step();
        move_i = 1'b0;
`ifdef ASTE_WRAP_EN
        check("off.active", 32'(active_o), 32'hD);
        check_slot("off.s0", 0, 0, 7, 0);
        check_slot("off.s2", 2, 7, 0, 2);
        check_slot("off.s3", 3, 7, 14, 3);
`else
        check("off.active", 32'(active_o), 32'h0);
        check_slot("off.s0", 0, 14, 7, 0);
        check_slot("off.s2", 2, 7, 14, 2);
        check_slot("off.s3", 3, 7, 0, 3);
`endif

        // Back-to-back spawn requests: one load, one drop.
        spawn_i = 1'b1;
        step();
        step();
        spawn_i = 1'b0;
        check("b2b.drop", 32'(drop_o), 32'h1);
        check("b2b.busy", 32'(busy_o), 32'h1);
        step();
        check("b2b.drop_end", 32'(drop_o), 32'h0);
        check("b2b.addr", 32'(rom_addr_o), 32'h2);
`ifdef ASTE_WRAP_EN
        check("b2b.active", 32'(active_o), 32'hF);
        check_slot("b2b.s1", 1, 14, 7, 1);
`else
        check("b2b.active", 32'(active_o), 32'h1);
        check_slot("b2b.s0", 0, 14, 7, 1);
`endif
        step();
        check("b2b.no_second", 32'(busy_o), 32'h0);

        // Reset asserted during FETCH.
        spawn_i = 1'b1;
        step();
        spawn_i = 1'b0;
        check("rstf.busy_pre", 32'(busy_o), 32'h1);
        reset_n = 1'b0;
        step();
        check("rstf.busy", 32'(busy_o), 32'h0);
        check("rstf.active", 32'(active_o), 32'h0);
        check("rstf.addr", 32'(rom_addr_o), 32'h0);
        check("rstf.drop", 32'(drop_o), 32'h0);
        reset_n = 1'b1;
        step();
        step();
        check("rstf.stays_idle", 32'(busy_o), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
